// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the MIPS pipeline stages.
//   PCSRC_*     : next-PC select codes driven from ID
//   NOP_INST    : instruction word injected into IF/ID when nothing is delivered
//   fetch_state_e : instruction-fetch state encoding
//   word_align  : clears the byte-offset bits of a code address
package mips_pkg;
    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [31:0] NOP_INST = 32'h0;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: instruction-memory request/ready handshake.
//   imem_req   : fetch request valid (fetch -> memory)
//   imem_addr  : word fetch address (fetch -> memory)
//   imem_ready : imem_rdata valid for the current request (memory -> fetch)
//   imem_rdata : fetched word (memory -> fetch)
interface if_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input  imem_ready, imem_rdata);
    modport slave  (input  imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/if_fetch_npc_mux.sv
// npc_mux: combinational next-PC select for the fetch stage.
//   pcsource_i    : select from ID (seq / branch / jr / jump)
//   bpc_i/rpc_i/jpc_i : redirect targets, low two bits dropped
//   redir_valid_i : a redirect was latched while the delay slot was pending
//   redir_pc_i    : latched (already aligned) redirect target
//   pc_i          : current fetch PC
//   npc_o         : aligned next PC; with pcsource_i != SEQ this is also the
//                   aligned target the top latches as a pending redirect
module npc_mux
    import mips_pkg::*;
(
    input  logic [1:0]  pcsource_i,
    input  logic [31:0] bpc_i,
    input  logic [31:0] rpc_i,
    input  logic [31:0] jpc_i,
    input  logic        redir_valid_i,
    input  logic [31:0] redir_pc_i,
    input  logic [31:0] pc_i,
    output logic [31:0] npc_o
);
    always_comb begin
        case (pcsource_i)
            PCSRC_BR: npc_o = word_align(bpc_i);
            PCSRC_JR: npc_o = word_align(rpc_i);
            PCSRC_J:  npc_o = word_align(jpc_i);
            // A live redirect from ID beats an older latched one.
            default:  npc_o = redir_valid_i ? redir_pc_i : pc_i + 32'd4;
        endcase
    end
endmodule

// File: rtl/if_fetch.sv
// if_fetch: IF stage of the 5-stage MIPS pipeline.
//   clock, resetn : rising-edge clock, asynchronous active-low reset
//   LOADDEPEN     : load-use stall, IF/ID holds its contents
//   pcsource, bpc, rpc, jpc : next-PC select and targets from ID
//   imem          : instruction-memory handshake (master side)
//   inst_if       : instruction to IF/ID (0 = NOP)
//   pc4_if        : pc + 4 to IF/ID
// A word fetched while the stall is active is parked in hold_inst and the
// request is dropped until release. Redirects arriving while the delay slot
// has not been delivered are latched and applied at delivery.
module if_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        LOADDEPEN,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    if_fetch_if.master  imem,
    output logic [31:0] inst_if,
    output logic [31:0] pc4_if
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_inst_q, hold_inst_d;
    logic         redir_valid_q, redir_valid_d;
    logic [31:0]  redir_pc_q, redir_pc_d;
    logic [31:0]  npc;
    logic         fetch_hit;
    logic         deliver;

    npc_mux u_npc_mux (
        .pcsource_i    (pcsource),
        .bpc_i         (bpc),
        .rpc_i         (rpc),
        .jpc_i         (jpc),
        .redir_valid_i (redir_valid_q),
        .redir_pc_i    (redir_pc_q),
        .pc_i          (pc_q),
        .npc_o         (npc)
    );

    assign fetch_hit = (state_q == FETCH) && imem.imem_ready;
    // IF/ID takes a real instruction this edge.
    assign deliver   = !LOADDEPEN && (fetch_hit || (state_q == HOLD));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            hold_inst_q   <= NOP_INST;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_inst_q   <= hold_inst_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_inst_d   = hold_inst_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        if (deliver) begin
            pc_d          = npc;
            redir_valid_d = 1'b0;
            state_d       = FETCH;
        end else begin
            if (fetch_hit && LOADDEPEN) begin
                hold_inst_d = imem.imem_rdata;
                state_d     = HOLD;
            end
            // Delay slot still pending: remember the target, newest wins.
            if (pcsource != PCSRC_SEQ) begin
                redir_valid_d = 1'b1;
                redir_pc_d    = npc;
            end
        end
    end

    always_comb begin
        imem.imem_req  = resetn && (state_q == FETCH);
        imem.imem_addr = pc_q;
        pc4_if         = pc_q + 32'd4;
        if (!resetn)              inst_if = NOP_INST;
        else if (fetch_hit)       inst_if = imem.imem_rdata;
        else if (state_q == HOLD) inst_if = hold_inst_q;
        else                      inst_if = NOP_INST;
    end
endmodule
